mpu_load_stream: RTL and testbench
==================================

Name: mpu_load_stream

Overview:
- Parametrised multi-lane matrix loader that moves a matrix from an external memory/file stream into the matrix register file.
- Accepts LANES elements per beat under a valid/ready handshake and supports back-pressure, partial row beats, optional transpose-on-load and abort.
- Sits between the external memory interface and the register file write port.
- Successor to the single-element loader.

Parameters:
FP, 32, element width in bits (32 or 64 float)
M, 4, max rows of a matrix register
N, 4, max columns of a matrix register
MBITS, $clog2(M), row index width (size ports are MBITS+1 bits)
NBITS, $clog2(N), column index width (size ports are NBITS+1 bits)
MATRIX_REG_SIZE, 4, matrix register address width
LANES, 2, elements per beat (power of two, 1 ≤ LANES ≤ min(M,N))

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
load_req_in  in  1  load request; sampled in IDLE only
load_transpose_in  in  1  store transposed; sampled with request
mem_m_size_in  in  MBITS+1  source rows
mem_n_size_in  in  NBITS+1  source columns
mem_load_addr_in  in  MATRIX_REG_SIZE  destination register
load_abort_in  in  1  abandon active load
load_gnt_out  out  1  one-cycle pulse: request accepted
load_error_out  out  1  sticky dimension error
load_done_out  out  1  one-cycle pulse after last write
mem_valid_in  in  1  beat valid
mem_data_in  in  LANES*FP  beat; lane k at bits [k*FP +: FP]
mem_ready_out  out  1  loader can accept a beat
reg_load_en_out  out  1  register-file write strobe
reg_lane_en_out  out  LANES  per-lane write enable
reg_load_addr_out  out  MATRIX_REG_SIZE  destination register
reg_load_element_out  out  LANES*FP  write data
reg_i_load_loc_out  out  MBITS+1  lane-0 row location
reg_j_load_loc_out  out  NBITS+1  lane-0 column location
reg_transpose_out  out  1  0: lane k targets column j+k; 1: lane k targets row i+k
reg_m_size_out  out  MBITS+1  stored rows (n when transposed)
reg_n_size_out  out  NBITS+1  stored columns (m when transposed)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. A reset asserted mid-load aborts the load without a done pulse and clears load_error_out.
- States are IDLE, STREAM and DONE.
- IDLE, load_req_in=1:
  - Normal load: error if m=0, n=0, m>M or n>N.
  - Transposed load: error if m=0, n=0, n>M or m>N.
  - On error: set load_error_out, no grant, stay IDLE.
  - Otherwise: load_gnt_out=1 for one cycle, clear load_error_out, latch address, sizes and transpose flag, then move to STREAM.
- STREAM:
  - mem_ready_out=1.
  - A beat transfers on mem_valid_in && mem_ready_out.
  - Source order is row-major. Each source row takes ceil(n/LANES) beats, and beats never span rows.
  - On the last beat of a row, lanes with column ≥ n are masked in reg_lane_en_out; their data is don't-care.
- Write timing: a beat accepted in cycle t produces reg_load_en_out=1 in cycle t+1 with registered data and locations.
  - Non-transposed: i = source row, j = source column of lane 0.
  - Transposed: i = source column of lane 0, j = source row.
  - reg_load_en_out=0 in every cycle following a cycle with no transfer.
  - Stored sizes and address are held stable from grant until DONE exits.
- Completion: the transfer of the final beat (row m-1, last beat) moves the FSM to DONE and drops mem_ready_out the next cycle. DONE lasts one cycle with load_done_out=1; this cycle coincides with the final write strobe. The FSM then returns to IDLE.
- Abort: load_abort_in in STREAM moves to IDLE next cycle with no done pulse. A beat transferred in the abort cycle is discarded (no write). Abort has priority over a simultaneous final beat.
- Counters: column pointer advances by LANES and wraps to 0 when ≥ n, at which point the row pointer increments. There is no overflow past m.
- Back-pressure: ready is never dependent on valid. No beat is dropped or duplicated with arbitrary valid gaps.

Test Plan:
- m=2, n=3, addr=1, LANES=2, continuous valid (4 beats): writes (0,0) lanes 11, (0,2) lanes 01, (1,0) lanes 11, (1,2) lanes 01; done pulse in cycle of 4th write.
- Same load with valid toggling 1,0,1,0: exactly 4 writes, data order preserved, no duplicates.
- m=3, n=2, transpose=1: reg_m_size_out=2, reg_n_size_out=3, reg_transpose_out=1; source row r written at i=0, j=r, lanes 11.
- m=5 (M=4) → load_error_out=1, no grant. Then m=n=1 → grant, error cleared, one write with lanes 01.
- Abort after 2 beats of a 4x4 load: 2 writes only, no done; IDLE next cycle; new request granted.
- rst during STREAM: all outputs 0 next cycle, mem_ready_out=0, no done pulse.

Source files
------------

// File: rtl/mpu_load_stream.sv
// Multi-lane matrix loader: accepts LANES elements per beat from a memory
// stream and turns each beat into a registered register-file write. It can
// optionally store the matrix transposed.
module mpu_load_stream #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 4,
  parameter int LANES           = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req_in,
  input  logic                       load_transpose_in,
  input  logic [MBITS:0]             mem_m_size_in,
  input  logic [NBITS:0]             mem_n_size_in,
  input  logic [MATRIX_REG_SIZE-1:0] mem_load_addr_in,
  input  logic                       load_abort_in,
  output logic                       load_gnt_out,
  output logic                       load_error_out,
  output logic                       load_done_out,
  input  logic                       mem_valid_in,
  input  logic [LANES*FP-1:0]        mem_data_in,
  output logic                       mem_ready_out,
  output logic                       reg_load_en_out,
  output logic [LANES-1:0]           reg_lane_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
  output logic [LANES*FP-1:0]        reg_load_element_out,
  output logic [MBITS:0]             reg_i_load_loc_out,
  output logic [NBITS:0]             reg_j_load_loc_out,
  output logic                       reg_transpose_out,
  output logic [MBITS:0]             reg_m_size_out,
  output logic [NBITS:0]             reg_n_size_out
);

  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;
  // One extra bit so that column + LANES cannot wrap around.
  localparam int CW = NBITS + 2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [MW-1:0]   m_size;
  logic [NW-1:0]   n_size;
  logic            transpose;
  logic [MW-1:0]   row_ptr;
  logic [NW-1:0]   col_ptr;

  logic            size_err;
  logic            xfer;
  logic [CW-1:0]   col_next;
  logic            row_last_beat;
  logic            final_beat;
  logic [LANES-1:0] lane_mask;

  // Request legality, beat-position decode and per-lane masking.
  always_comb begin
    size_err      = 1'b0;
    xfer          = 1'b0;
    col_next      = CW'(col_ptr) + CW'(LANES);
    row_last_beat = 1'b0;
    final_beat    = 1'b0;
    lane_mask     = '0;
    if (load_transpose_in) begin
      size_err = (mem_m_size_in == '0) || (mem_n_size_in == '0) ||
                 (int'(mem_n_size_in) > M) || (int'(mem_m_size_in) > N);
    end else begin
      size_err = (mem_m_size_in == '0) || (mem_n_size_in == '0) ||
                 (int'(mem_m_size_in) > M) || (int'(mem_n_size_in) > N);
    end
    // A beat arriving together with an abort is dropped.
    xfer          = (state == STREAM) && mem_valid_in && !load_abort_in;
    row_last_beat = (col_next >= CW'(n_size));
    final_beat    = row_last_beat && (row_ptr == (m_size - MW'(1)));
    for (int k = 0; k < LANES; k++) begin
      lane_mask[k] = ((int'(col_ptr) + k) < int'(n_size));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the state-decoded handshake outputs.
  always_comb begin
    next_state    = state;
    mem_ready_out = 1'b0;
    load_done_out = 1'b0;
    case (state)
      IDLE: begin
        if (load_req_in && !size_err) begin
          next_state = STREAM;
        end
      end
      STREAM: begin
        mem_ready_out = 1'b1;
        if (load_abort_in) begin
          next_state = IDLE;
        end else if (xfer && final_beat) begin
          next_state = DONE;
        end
      end
      DONE: begin
        load_done_out = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, beat counters and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_gnt_out         <= 1'b0;
      load_error_out       <= 1'b0;
      m_size               <= '0;
      n_size               <= '0;
      transpose            <= 1'b0;
      row_ptr              <= '0;
      col_ptr              <= '0;
      reg_load_en_out      <= 1'b0;
      reg_lane_en_out      <= '0;
      reg_load_addr_out    <= '0;
      reg_load_element_out <= '0;
      reg_i_load_loc_out   <= '0;
      reg_j_load_loc_out   <= '0;
      reg_m_size_out       <= '0;
      reg_n_size_out       <= '0;
    end else begin
      load_gnt_out <= 1'b0;
      if ((state == IDLE) && load_req_in) begin
        if (size_err) begin
          load_error_out <= 1'b1;
        end else begin
          load_gnt_out      <= 1'b1;
          load_error_out    <= 1'b0;
          m_size            <= mem_m_size_in;
          n_size            <= mem_n_size_in;
          transpose         <= load_transpose_in;
          reg_load_addr_out <= mem_load_addr_in;
          row_ptr           <= '0;
          col_ptr           <= '0;
          if (load_transpose_in) begin
            reg_m_size_out <= MW'(mem_n_size_in);
            reg_n_size_out <= NW'(mem_m_size_in);
          end else begin
            reg_m_size_out <= mem_m_size_in;
            reg_n_size_out <= mem_n_size_in;
          end
        end
      end

      reg_load_en_out <= xfer;
      reg_lane_en_out <= xfer ? lane_mask : '0;
      if (xfer) begin
        reg_load_element_out <= mem_data_in;
        if (transpose) begin
          reg_i_load_loc_out <= MW'(col_ptr);
          reg_j_load_loc_out <= NW'(row_ptr);
        end else begin
          reg_i_load_loc_out <= row_ptr;
          reg_j_load_loc_out <= col_ptr;
        end
        if (row_last_beat) begin
          col_ptr <= '0;
          if (!final_beat) begin
            row_ptr <= row_ptr + MW'(1);
          end
        end else begin
          col_ptr <= NW'(col_next);
        end
      end
    end
  end

  assign reg_transpose_out = transpose;

endmodule

// File: tb/tb_mpu_load_stream.sv
// Self-checking bench for mpu_load_stream: a row-major write-list model
// generated from each source matrix, checked on every write strobe.
module tb_mpu_load_stream;

  localparam int FP    = 32;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int MBITS = 2;
  localparam int NBITS = 2;
  localparam int MRS   = 4;
  localparam int LANES = 2;
  localparam int MW    = MBITS + 1;
  localparam int NW    = NBITS + 1;
  localparam int DW    = LANES * FP;

  logic           clk;
  logic           rst;
  logic           load_req_in;
  logic           load_transpose_in;
  logic [MW-1:0]  mem_m_size_in;
  logic [NW-1:0]  mem_n_size_in;
  logic [MRS-1:0] mem_load_addr_in;
  logic           load_abort_in;
  logic           load_gnt_out;
  logic           load_error_out;
  logic           load_done_out;
  logic           mem_valid_in;
  logic [DW-1:0]  mem_data_in;
  logic           mem_ready_out;
  logic           reg_load_en_out;
  logic [LANES-1:0] reg_lane_en_out;
  logic [MRS-1:0] reg_load_addr_out;
  logic [DW-1:0]  reg_load_element_out;
  logic [MW-1:0]  reg_i_load_loc_out;
  logic [NW-1:0]  reg_j_load_loc_out;
  logic           reg_transpose_out;
  logic [MW-1:0]  reg_m_size_out;
  logic [NW-1:0]  reg_n_size_out;

  mpu_load_stream #(
    .FP(FP), .M(M), .N(N), .MBITS(MBITS), .NBITS(NBITS),
    .MATRIX_REG_SIZE(MRS), .LANES(LANES)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .load_req_in         (load_req_in),
    .load_transpose_in   (load_transpose_in),
    .mem_m_size_in       (mem_m_size_in),
    .mem_n_size_in       (mem_n_size_in),
    .mem_load_addr_in    (mem_load_addr_in),
    .load_abort_in       (load_abort_in),
    .load_gnt_out        (load_gnt_out),
    .load_error_out      (load_error_out),
    .load_done_out       (load_done_out),
    .mem_valid_in        (mem_valid_in),
    .mem_data_in         (mem_data_in),
    .mem_ready_out       (mem_ready_out),
    .reg_load_en_out     (reg_load_en_out),
    .reg_lane_en_out     (reg_lane_en_out),
    .reg_load_addr_out   (reg_load_addr_out),
    .reg_load_element_out(reg_load_element_out),
    .reg_i_load_loc_out  (reg_i_load_loc_out),
    .reg_j_load_loc_out  (reg_j_load_loc_out),
    .reg_transpose_out   (reg_transpose_out),
    .reg_m_size_out      (reg_m_size_out),
    .reg_n_size_out      (reg_n_size_out)
  );

  typedef struct {
    logic [MW-1:0]    i;
    logic [NW-1:0]    j;
    logic [LANES-1:0] lanes;
    logic [DW-1:0]    data;
    bit               last;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] beat_q[$];
  wr_t           cmp_w;
  int            tests_run   = 0;
  int            tests_failed = 0;
  int            write_count = 0;
  int            load_id     = 0;
  logic [MRS-1:0] cur_addr   = '0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s", name);
  endtask

  function automatic logic [FP-1:0] elem(input int r, input int c);
    return FP'(32'h1000_0000 + (load_id << 8) + (r << 4) + c);
  endfunction

  function automatic logic [DW-1:0] lane_bits(input logic [LANES-1:0] l);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) if (l[k]) m[k*FP +: FP] = '1;
    return m;
  endfunction

  // Enumerate the source matrix row by row, LANES columns at a time, and
  // record both the beats to send and the writes that must come out.
  function automatic void build_model(input int m, input int n, input bit tr);
    wr_t           w;
    logic [DW-1:0] beat;
    exp_q.delete();
    beat_q.delete();
    load_id++;
    for (int r = 0; r < m; r++) begin
      for (int c0 = 0; c0 < n; c0 += LANES) begin
        beat    = '0;
        w.data  = '0;
        w.lanes = '0;
        for (int k = 0; k < LANES; k++) begin
          if (c0 + k < n) begin
            w.lanes[k]            = 1'b1;
            beat[k*FP +: FP]      = elem(r, c0 + k);
            w.data[k*FP +: FP]    = elem(r, c0 + k);
          end else begin
            beat[k*FP +: FP] = FP'(32'hDEAD_0000 + k);
          end
        end
        w.i    = tr ? MW'(c0) : MW'(r);
        w.j    = tr ? NW'(r)  : NW'(c0);
        w.last = (r == m - 1) && (c0 + LANES >= n);
        exp_q.push_back(w);
        beat_q.push_back(beat);
      end
    end
  endfunction

  // Every write strobe is matched against the head of the expected list.
  always @(negedge clk) begin
    if (reg_load_en_out === 1'b1 || load_done_out === 1'b1) begin
      if (reg_load_en_out !== 1'b1) begin
        fail_now("done_without_write");
      end else if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        cmp_w = exp_q.pop_front();
        write_count++;
        checkOutput("wr_i", reg_i_load_loc_out, cmp_w.i);
        checkOutput("wr_j", reg_j_load_loc_out, cmp_w.j);
        checkOutput("wr_lanes", reg_lane_en_out, cmp_w.lanes);
        checkOutput("wr_data", reg_load_element_out & lane_bits(cmp_w.lanes), cmp_w.data);
        checkOutput("wr_addr", reg_load_addr_out, cur_addr);
        checkOutput("wr_done", load_done_out, cmp_w.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load request and check the grant/error response one cycle later.
  task automatic applyStimulus(input int m, input int n, input bit tr,
                               input int addr, input bit expect_ok);
    load_req_in       = 1'b1;
    mem_m_size_in     = MW'(m);
    mem_n_size_in     = NW'(n);
    load_transpose_in = tr;
    mem_load_addr_in  = MRS'(addr);
    tick();
    load_req_in = 1'b0;
    if (expect_ok) begin
      cur_addr = MRS'(addr);
      checkOutput("gnt", load_gnt_out, 1);
      checkOutput("err_clear", load_error_out, 0);
      checkOutput("ready_stream", mem_ready_out, 1);
      checkOutput("m_size", reg_m_size_out, tr ? n : m);
      checkOutput("n_size", reg_n_size_out, tr ? m : n);
      checkOutput("transpose", reg_transpose_out, tr);
      checkOutput("addr", reg_load_addr_out, addr);
    end else begin
      checkOutput("no_gnt", load_gnt_out, 0);
      checkOutput("err_set", load_error_out, 1);
      checkOutput("ready_idle", mem_ready_out, 0);
    end
  endtask

  // Offer beats from beat_q in order; optionally drop valid for a cycle
  // after each accepted beat.
  task automatic stream_beats(input int count, input bit gaps);
    bit ok;
    for (int b = 0; b < count; b++) begin
      mem_data_in  = beat_q[b];
      mem_valid_in = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = mem_ready_out;
        @(posedge clk);
        #1;
      end
      if (!ok) fail_now("beat_timeout");
      if (gaps) begin
        mem_valid_in = 1'b0;
        tick();
      end
    end
    mem_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    checkOutput("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ready"}, mem_ready_out, 0);
    checkOutput({tag, "_gnt"}, load_gnt_out, 0);
    checkOutput({tag, "_err"}, load_error_out, 0);
    checkOutput({tag, "_done"}, load_done_out, 0);
    checkOutput({tag, "_en"}, reg_load_en_out, 0);
    checkOutput({tag, "_lanes"}, reg_lane_en_out, 0);
    checkOutput({tag, "_addr"}, reg_load_addr_out, 0);
    checkOutput({tag, "_msize"}, reg_m_size_out, 0);
    checkOutput({tag, "_nsize"}, reg_n_size_out, 0);
    checkOutput({tag, "_tr"}, reg_transpose_out, 0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wc;
    rst               = 1'b1;
    load_req_in       = 1'b0;
    load_transpose_in = 1'b0;
    mem_m_size_in     = '0;
    mem_n_size_in     = '0;
    mem_load_addr_in  = '0;
    load_abort_in     = 1'b0;
    mem_valid_in      = 1'b0;
    mem_data_in       = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 2x3 load, continuous valid.
    build_model(2, 3, 0);
    checkOutput("model_t1_count", exp_q.size(), 4);
    checkOutput("model_t1_j1", exp_q[1].j, 2);
    checkOutput("model_t1_lanes1", exp_q[1].lanes, 2'b01);
    checkOutput("model_t1_lanes2", exp_q[2].lanes, 2'b11);
    checkOutput("model_t1_i3", exp_q[3].i, 1);
    wc = write_count;
    applyStimulus(2, 3, 0, 1, 1);
    tick();
    checkOutput("gnt_pulse", load_gnt_out, 0);
    stream_beats(4, 0);
    checkOutput("t1_done_cycle", load_done_out, 1);
    checkOutput("t1_ready_done", mem_ready_out, 0);
    tick();
    checkOutput("t1_done_drop", load_done_out, 0);
    checkOutput("t1_idle_ready", mem_ready_out, 0);
    drain();
    checkOutput("t1_writes", write_count - wc, 4);

    // Same load, valid toggling.
    build_model(2, 3, 0);
    wc = write_count;
    applyStimulus(2, 3, 0, 1, 1);
    stream_beats(4, 1);
    drain();
    checkOutput("t2_writes", write_count - wc, 4);

    // Transposed 3x2 load.
    build_model(3, 2, 1);
    checkOutput("model_t3_count", exp_q.size(), 3);
    checkOutput("model_t3_i2", exp_q[2].i, 0);
    checkOutput("model_t3_j2", exp_q[2].j, 2);
    checkOutput("model_t3_lanes2", exp_q[2].lanes, 2'b11);
    wc = write_count;
    applyStimulus(3, 2, 1, 2, 1);
    stream_beats(3, 0);
    drain();
    checkOutput("t3_writes", write_count - wc, 3);

    // Dimension errors, then a minimal 1x1 load clears the error.
    applyStimulus(5, 2, 0, 3, 0);
    applyStimulus(2, 5, 1, 3, 0);
    build_model(1, 1, 0);
    checkOutput("model_t4_lanes", exp_q[0].lanes, 2'b01);
    wc = write_count;
    applyStimulus(1, 1, 0, 3, 1);
    stream_beats(1, 0);
    drain();
    checkOutput("t4_writes", write_count - wc, 1);

    // Abort after two beats of a 4x4 load; third beat offered in abort cycle.
    build_model(4, 4, 0);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    exp_q[1].last = 1'b0;
    wc = write_count;
    applyStimulus(4, 4, 0, 5, 1);
    stream_beats(2, 0);
    mem_data_in   = beat_q[2];
    mem_valid_in  = 1'b1;
    load_abort_in = 1'b1;
    tick();
    load_abort_in = 1'b0;
    mem_valid_in  = 1'b0;
    checkOutput("abort_ready", mem_ready_out, 0);
    checkOutput("abort_done", load_done_out, 0);
    checkOutput("abort_no_write", reg_load_en_out, 0);
    drain();
    checkOutput("abort_writes", write_count - wc, 2);
    build_model(1, 2, 0);
    applyStimulus(1, 2, 0, 6, 1);
    stream_beats(1, 0);
    drain();

    // Reset in the middle of a stream.
    build_model(2, 3, 0);
    applyStimulus(2, 3, 0, 7, 1);
    stream_beats(1, 0);
    rst          = 1'b1;
    mem_data_in  = beat_q[1];
    mem_valid_in = 1'b1;
    tick();
    rst          = 1'b0;
    mem_valid_in = 1'b0;
    exp_q.delete();
    check_all_zero("midrst");
    repeat (4) tick();
    checkOutput("midrst_ready_later", mem_ready_out, 0);

    // Reset clears a sticky error (m=0 boundary).
    applyStimulus(0, 2, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_clears_err", load_error_out, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
